// File: rtl/beat_track_multiband.sv
// Multiband beat tracker: accumulates FFT magnitudes into programmable bin ranges per frame
// and fires per-band beats against a fixed or running-average-relative threshold.
module beat_track_multiband #(
  parameter int N_BANDS   = 2,
  parameter int BIN_W     = 6,
  parameter int ACC_W     = 24,
  parameter int WAIT_W    = 8,
  parameter int AVG_SHIFT = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [BIN_W-1:0]           sample_ctr,
  input  logic [31:0]                data,
  input  logic                       fft_write,
  input  logic [N_BANDS*BIN_W-1:0]   band_lo,
  input  logic [N_BANDS*BIN_W-1:0]   band_hi,
  input  logic [N_BANDS*16-1:0]      thresh,
  input  logic [WAIT_W-1:0]          wait_frames,
  input  logic                       adaptive,
  output logic [N_BANDS-1:0]         beat_out,
  output logic                       beat_any,
  output logic [N_BANDS*ACC_W-1:0]   energy,
  output logic                       frame_valid
);

  localparam int SUM_W = ((ACC_W > 17) ? ACC_W : 17) + 1;
  localparam int LVL_W = ((ACC_W > 16) ? ACC_W : 16) + 1;
  localparam logic [ACC_W-1:0]  ACC_MAX  = {ACC_W{1'b1}};
  localparam logic [WAIT_W-1:0] WAIT_MAX = {WAIT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EVAL = 2'd2
  } state_t;

  state_t state_r;
  state_t state_s;

  logic [ACC_W-1:0]        acc_r     [N_BANDS];
  logic [ACC_W-1:0]        avg_r     [N_BANDS];
  logic [WAIT_W-1:0]       wait_r    [N_BANDS];
  logic [ACC_W-1:0]        base_s    [N_BANDS];
  logic [ACC_W-1:0]        acc_add_s [N_BANDS];
  logic [LVL_W-1:0]        lvl_sum_s [N_BANDS];
  logic [LVL_W-1:0]        level_s   [N_BANDS];
  logic signed [ACC_W:0]   diff_s    [N_BANDS];
  logic signed [ACC_W:0]   avg_new_s [N_BANDS];
  logic [N_BANDS-1:0]      in_band_s;
  logic [N_BANDS-1:0]      hit_s;
  logic [N_BANDS-1:0]      beat_s;
  logic [16:0]             mag_s;

  // -32768 has no 16-bit positive twin, so the magnitude is formed at 17 bits
  function automatic logic [16:0] abs17(input logic [15:0] v);
    if (v[15]) begin
      abs17 = 17'd0 - {v[15], v};
    end else begin
      abs17 = {1'b0, v};
    end
  endfunction

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a, input logic [16:0] m);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(m);
    if (s > SUM_W'(ACC_MAX)) begin
      sat_add = ACC_MAX;
    end else begin
      sat_add = s[ACC_W-1:0];
    end
  endfunction

  // Sample magnitude
  always_comb begin
    mag_s = abs17(data[31:16]) + abs17(data[15:0]);
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (fft_write) state_s = LOAD;
        else           state_s = IDLE;
      end
      LOAD: begin
        if (fft_write) state_s = LOAD;
        else           state_s = EVAL;
      end
      EVAL: begin
        if (fft_write) state_s = LOAD;
        else           state_s = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Per-band accumulate, threshold and running-average datapath
  always_comb begin
    for (int k = 0; k < N_BANDS; k++) begin
      in_band_s[k] = fft_write
                   && (sample_ctr >= band_lo[k*BIN_W +: BIN_W])
                   && (sample_ctr <= band_hi[k*BIN_W +: BIN_W]);
      // Outside LOAD a sample always opens a fresh frame, so the base is zero
      if (state_r == LOAD) begin
        base_s[k] = acc_r[k];
      end else begin
        base_s[k] = {ACC_W{1'b0}};
      end
      if (in_band_s[k]) begin
        acc_add_s[k] = sat_add(base_s[k], mag_s);
      end else begin
        acc_add_s[k] = base_s[k];
      end
      lvl_sum_s[k] = LVL_W'(avg_r[k]) + LVL_W'(thresh[k*16 +: 16]);
      if (!adaptive) begin
        level_s[k] = LVL_W'(thresh[k*16 +: 16]);
      end else if (lvl_sum_s[k] > LVL_W'(ACC_MAX)) begin
        level_s[k] = LVL_W'(ACC_MAX);
      end else begin
        level_s[k] = lvl_sum_s[k];
      end
      hit_s[k]     = LVL_W'(acc_r[k]) > level_s[k];
      beat_s[k]    = hit_s[k] && (wait_r[k] >= wait_frames);
      diff_s[k]    = $signed({1'b0, acc_r[k]}) - $signed({1'b0, avg_r[k]});
      avg_new_s[k] = $signed({1'b0, avg_r[k]}) + (diff_s[k] >>> AVG_SHIFT);
    end
  end

  // State, accumulators, band statistics and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      beat_out    <= {N_BANDS{1'b0}};
      beat_any    <= 1'b0;
      frame_valid <= 1'b0;
      energy      <= {(N_BANDS*ACC_W){1'b0}};
      for (int k = 0; k < N_BANDS; k++) begin
        acc_r[k]  <= {ACC_W{1'b0}};
        avg_r[k]  <= {ACC_W{1'b0}};
        wait_r[k] <= WAIT_MAX;
      end
    end else begin
      state_r     <= state_s;
      beat_out    <= {N_BANDS{1'b0}};
      beat_any    <= 1'b0;
      frame_valid <= 1'b0;
      for (int k = 0; k < N_BANDS; k++) begin
        case (state_r)
          IDLE, LOAD, EVAL: acc_r[k] <= acc_add_s[k];
          default:          acc_r[k] <= {ACC_W{1'b0}};
        endcase
      end
      if (state_r == EVAL) begin
        frame_valid <= 1'b1;
        beat_out    <= beat_s;
        beat_any    <= |beat_s;
        for (int k = 0; k < N_BANDS; k++) begin
          energy[k*ACC_W +: ACC_W] <= acc_r[k];
          avg_r[k] <= avg_new_s[k][ACC_W-1:0];
          if (beat_s[k]) begin
            wait_r[k] <= {WAIT_W{1'b0}};
          end else if (wait_r[k] != WAIT_MAX) begin
            wait_r[k] <= wait_r[k] + {{(WAIT_W-1){1'b0}}, 1'b1};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_beat_track_multiband.sv
// Scoreboard bench for beat_track_multiband: randomized and directed frames checked against
// a frame-level reference model of band energies, thresholds, refractory and running average.
module tb_beat_track_multiband;

  localparam longint EMAX = 64'd16777215;

  logic        clk;
  logic        reset;
  logic [5:0]  sample_ctr;
  logic [31:0] data;
  logic        fft_write;
  logic [11:0] band_lo;
  logic [11:0] band_hi;
  logic [31:0] thresh;
  logic [7:0]  wait_frames;
  logic        adaptive;
  logic [1:0]  beat_out;
  logic        beat_any;
  logic [47:0] energy;
  logic        frame_valid;

  beat_track_multiband dut (
    .clk(clk), .reset(reset), .sample_ctr(sample_ctr), .data(data), .fft_write(fft_write),
    .band_lo(band_lo), .band_hi(band_hi), .thresh(thresh), .wait_frames(wait_frames),
    .adaptive(adaptive), .beat_out(beat_out), .beat_any(beat_any), .energy(energy),
    .frame_valid(frame_valid)
  );

  typedef struct {
    longint e0;
    longint e1;
    logic [1:0] b;
    int cyc;
  } exp_t;

  exp_t   q[$];
  int     tests = 0;
  int     fails = 0;
  int     cyc = 0;
  bit     started = 0;
  longint m_avg[2];
  longint m_wait[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic longint mag(input logic [31:0] d);
    int re, im;
    re = int'($signed(d[31:16]));
    im = int'($signed(d[15:0]));
    return longint'((re < 0) ? -re : re) + longint'((im < 0) ? -im : im);
  endfunction

  function automatic bit member(input int k, input logic [5:0] c);
    logic [5:0] lo, hi;
    lo = band_lo[k*6 +: 6];
    hi = band_hi[k*6 +: 6];
    return (c >= lo) && (c <= hi);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_avg[k]  = 0;
      m_wait[k] = 255;
    end
  endtask

  // Frame-level evaluation of the band rules; called on the cycle fft_write drops.
  task automatic model_eval(input longint s0, input longint s1);
    exp_t x;
    longint e, th, lvl, d, step;
    bit bt;
    for (int k = 0; k < 2; k++) begin
      e = (k == 0) ? s0 : s1;
      if (e > EMAX) e = EMAX;
      th = longint'(thresh[k*16 +: 16]);
      lvl = adaptive ? ((m_avg[k] + th > EMAX) ? EMAX : m_avg[k] + th) : th;
      bt = (e > lvl) && (m_wait[k] >= longint'(wait_frames));
      x.b[k] = bt;
      m_wait[k] = bt ? 0 : ((m_wait[k] == 255) ? 255 : m_wait[k] + 1);
      d = e - m_avg[k];
      step = (d >= 0) ? d / 8 : -((-d + 7) / 8);
      m_avg[k] = m_avg[k] + step;
      if (k == 0) x.e0 = e; else x.e1 = e;
    end
    x.cyc = cyc + 2;
    q.push_back(x);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      fft_write = 1'b0;
    end
  endtask

  task automatic run_frame(input int len, input int start, input bit rnd, input logic [31:0] fdat,
                           input logic [31:0] mask, input int gap);
    longint s0, s1;
    s0 = 0;
    s1 = 0;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      fft_write  = 1'b1;
      sample_ctr = 6'((start + i) % 64);
      data       = rnd ? ($urandom & mask) : fdat;
      if (member(0, sample_ctr)) s0 += mag(data);
      if (member(1, sample_ctr)) s1 += mag(data);
    end
    @(negedge clk);
    fft_write = 1'b0;
    model_eval(s0, s1);
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic set_cfg(input int lo0, input int hi0, input int lo1, input int hi1,
                         input int t0, input int t1, input int wf, input bit ad);
    idle(3);
    band_lo     = {6'(lo1), 6'(lo0)};
    band_hi     = {6'(hi1), 6'(hi0)};
    thresh      = {16'(t1), 16'(t0)};
    wait_frames = 8'(wf);
    adaptive    = ad;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_energy"}, 64'(energy), 64'd0);
    check({tag, "_beat_out"}, 64'(beat_out), 64'd0);
    check({tag, "_beat_any"}, 64'(beat_any), 64'd0);
    check({tag, "_frame_valid"}, 64'(frame_valid), 64'd0);
  endtask

  task automatic do_reset();
    idle(3);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    check_quiet("reset");
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a frame result
  always @(negedge clk) begin
    exp_t x;
    if (started && !reset) begin
      if (frame_valid) begin
        if (q.size() == 0) begin
          check("stray_frame_valid", 64'd1, 64'd0);
        end else begin
          x = q.pop_front();
          check("energy0", 64'(energy[23:0]), 64'(x.e0));
          check("energy1", 64'(energy[47:24]), 64'(x.e1));
          check("beat_out", 64'(beat_out), 64'(x.b));
          check("beat_any", 64'(beat_any), 64'(|x.b));
          check("latency", 64'(cyc), 64'(x.cyc));
        end
      end else begin
        check("idle_beats", 64'({beat_out, beat_any}), 64'd0);
      end
    end
  end

  initial begin
    reset = 1'b1; fft_write = 1'b0; sample_ctr = 6'd0; data = 32'd0;
    band_lo = 12'd0; band_hi = 12'd0; thresh = 32'd0; wait_frames = 8'd0; adaptive = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_quiet("reset");
    started = 1;

    // mag 150, band0=[10,16], band1=[0,3]
    set_cfg(10, 16, 0, 3, 500, 500, 0, 1'b0);
    run_frame(32, 0, 1'b0, 32'h0064FFCE, 32'hFFFFFFFF, 3);
    // first bin of a frame from IDLE
    set_cfg(10, 16, 0, 0, 500, 5, 0, 1'b0);
    run_frame(32, 0, 1'b0, 32'h00070000, 32'hFFFFFFFF, 3);
    // refractory spacing
    set_cfg(0, 7, 0, 7, 100, 100, 3, 1'b0);
    for (int i = 0; i < 10; i++) run_frame(8, 0, 1'b0, 32'h0064FFCE, 32'hFFFFFFFF, 3);
    // refractory counter saturation after long quiet
    set_cfg(0, 7, 0, 7, 65535, 65535, 250, 1'b0);
    for (int i = 0; i < 260; i++) run_frame(1, 0, 1'b0, 32'h00010000, 32'hFFFFFFFF, 1);
    set_cfg(0, 7, 0, 7, 10, 10, 250, 1'b0);
    run_frame(8, 0, 1'b0, 32'h0064FFCE, 32'hFFFFFFFF, 3);

    // adaptive threshold, constant energy 800 then a 950 frame
    do_reset();
    set_cfg(0, 9, 0, 9, 10, 10, 0, 1'b1);
    for (int i = 0; i < 40; i++) run_frame(10, 0, 1'b0, 32'h00500000, 32'hFFFFFFFF, 2);
    run_frame(10, 0, 1'b0, 32'h005F0000, 32'hFFFFFFFF, 3);
    for (int i = 0; i < 5; i++) run_frame(10, 0, 1'b0, 32'h00500000, 32'hFFFFFFFF, 2);

    // back-to-back frames, then an inverted band
    set_cfg(5, 40, 0, 20, 3000, 20000, 1, 1'b0);
    for (int i = 0; i < 6; i++) run_frame($urandom_range(1, 40), $urandom_range(0, 63), 1'b1, 32'd0, 32'h0FFF0FFF, 1);
    set_cfg(20, 5, 0, 63, 100, 100, 0, 1'b0);
    for (int i = 0; i < 3; i++) run_frame(64, 0, 1'b1, 32'd0, 32'h00FF00FF, 1);

    // saturation: 600 samples of mag 65536
    set_cfg(0, 63, 0, 63, 500, 500, 0, 1'b0);
    run_frame(600, 0, 1'b0, 32'h80008000, 32'hFFFFFFFF, 3);

    // reset mid-burst discards the frame
    idle(4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      fft_write = 1'b1; sample_ctr = 6'(i); data = 32'h01000100;
    end
    @(negedge clk);
    reset = 1'b1; fft_write = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    check_quiet("midreset");
    idle(6);
    run_frame(20, 0, 1'b0, 32'h01000100, 32'hFFFFFFFF, 3);

    // randomized frames and configurations
    for (int r = 0; r < 30; r++) begin
      set_cfg($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 31), $urandom_range(0, 63),
              $urandom_range(0, 65535), $urandom_range(0, 4000), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
      for (int f = 0; f < 4; f++) begin
        run_frame($urandom_range(1, 40), $urandom_range(0, 63), 1'b1, 32'd0,
                  ($urandom_range(0, 1) == 1) ? 32'hFFFFFFFF : 32'h00FF00FF,
                  ($urandom_range(0, 2) == 0) ? 1 : $urandom_range(2, 5));
      end
    end

    begin : drain
      int budget;
      budget = 0;
      while (q.size() != 0 && budget < 50) begin
        @(negedge clk);
        budget++;
      end
      check("drain_pending", 64'(q.size()), 64'd0);
    end
    idle(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
